// File: rtl/step_clock_ctrl_pkg.sv
// Shared encodings and helpers for the step clock controller.
package step_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_FREE   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_clock_ctrl_if.sv
// Control/status bundle between the step clock controller and its host.
interface step_clock_ctrl_if #(
  parameter int unsigned BURST_W = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned TICK_W  = 8
);
  logic               button;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic [DIV_W-1:0]   div;
  logic               halt;
  logic               step_en;
  logic               step_clk;
  logic               busy;
  logic [TICK_W-1:0]  ticks;

  modport master (output button, mode, burst_len, div, halt,
                  input  step_en, step_clk, busy, ticks);
  modport slave  (input  button, mode, burst_len, div, halt,
                  output step_en, step_clk, busy, ticks);
endinterface

// File: rtl/step_clock_ctrl_btn_debounce.sv
// Two-flop synchroniser plus symmetric debouncer for the step button.
// press_acc_o pulses for one cycle per accepted press.
module btn_debounce
  import step_clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic press_acc_o
);
  localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync1_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync0_q <= button_i;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  // armed_q=1 waits for a stable-high run (press), armed_q=0 for a stable-low run (release).
  always_comb begin
    cnt_d   = '0;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync1_q == armed_q) begin
      if (cnt_q == CNT_LAST) begin
        armed_d = ~armed_q;
        press_d = armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_acc_o = press_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Step clock controller: turns debounced button presses into single, burst
// or free-running step strobes plus a registered step clock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a press; single steps are issued from here
//   ST_RUN  | burst or free-run in progress, steps every reload_q+1 cycles
module step_clock_ctrl
  import step_clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned PULSE_CYCLES    = 1,
  parameter int unsigned BURST_W         = 8,
  parameter int unsigned DIV_W           = 16,
  parameter int unsigned TICK_W          = 8
) (
  input logic clk,
  input logic reset,
  step_clock_ctrl_if.slave bus
);
  localparam int unsigned MIN_W = cnt_width(2 * PULSE_CYCLES);
  localparam int unsigned PER_W = (DIV_W > MIN_W) ? DIV_W : MIN_W;
  localparam int unsigned PW    = cnt_width(PULSE_CYCLES);
  localparam logic [PER_W-1:0] MIN_RELOAD = PER_W'(2 * PULSE_CYCLES - 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_CYCLES - 1);

  logic press_acc;
  logic issue;
  mode_e mode_in;
  logic [PER_W-1:0] div_ext, reload_in;

  state_e            state_q, state_d;
  logic              free_q, free_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [PER_W-1:0]  reload_q, reload_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic              step_en_q, step_en_d;
  logic              step_clk_q, step_clk_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .button_i   (bus.button),
    .press_acc_o(press_acc)
  );

  assign mode_in   = mode_e'(bus.mode);
  assign div_ext   = PER_W'(bus.div);
  // Period is reload+1, never shorter than two full step_clk pulses.
  assign reload_in = (div_ext > MIN_RELOAD) ? div_ext : MIN_RELOAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      free_q     <= 1'b0;
      rem_q      <= '0;
      reload_q   <= '0;
      per_q      <= '0;
      pulse_q    <= '0;
      step_en_q  <= 1'b0;
      step_clk_q <= 1'b0;
      ticks_q    <= '0;
    end else begin
      state_q    <= state_d;
      free_q     <= free_d;
      rem_q      <= rem_d;
      reload_q   <= reload_d;
      per_q      <= per_d;
      pulse_q    <= pulse_d;
      step_en_q  <= step_en_d;
      step_clk_q <= step_clk_d;
      ticks_q    <= ticks_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    free_d   = free_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    per_d    = per_q;
    issue    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press_acc && !bus.halt) begin
          case (mode_in)
            MODE_SINGLE: issue = 1'b1;
            MODE_BURST: begin
              if (bus.burst_len != '0) begin
                issue    = 1'b1;
                state_d  = ST_RUN;
                free_d   = 1'b0;
                rem_d    = bus.burst_len - 1'b1;
                reload_d = reload_in;
                per_d    = reload_in;
              end
            end
            MODE_FREE: begin
              issue    = 1'b1;
              state_d  = ST_RUN;
              free_d   = 1'b1;
              reload_d = reload_in;
              per_d    = reload_in;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Halt, a stopping press or an exhausted burst all take priority over expiry.
        if (bus.halt || (free_q && press_acc) || (!free_q && rem_q == '0)) begin
          state_d = ST_IDLE;
        end else if (per_q == '0) begin
          issue = 1'b1;
          per_d = reload_q;
          if (!free_q) rem_d = rem_q - 1'b1;
        end else begin
          per_d = per_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    step_en_d  = issue;
    ticks_d    = issue ? ticks_q + 1'b1 : ticks_q;
    step_clk_d = step_clk_q;
    pulse_d    = pulse_q;
    if (issue) begin
      step_clk_d = 1'b1;
      pulse_d    = PULSE_LAST;
    end else if (step_clk_q) begin
      if (pulse_q == '0) step_clk_d = 1'b0;
      else               pulse_d    = pulse_q - 1'b1;
    end
  end

  assign bus.step_en  = step_en_q;
  assign bus.step_clk = step_clk_q;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.ticks    = ticks_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed, table-driven bench for step_clock_ctrl (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2).
module tb_step_clock_ctrl;
  localparam int DEB = 4;
  localparam int PUL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  step_clock_ctrl_if #(.BURST_W(8), .DIV_W(16), .TICK_W(8)) bus ();
  step_clock_ctrl_if #(.BURST_W(8), .DIV_W(16), .TICK_W(2)) bus2 ();

  step_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .BURST_W(8), .DIV_W(16), .TICK_W(8))
    dut (.clk(clk), .reset(reset), .bus(bus));
  step_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .BURST_W(8), .DIV_W(16), .TICK_W(2))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.button    = bus.button;
  assign bus2.mode      = bus.mode;
  assign bus2.burst_len = bus.burst_len;
  assign bus2.div       = bus.div;
  assign bus2.halt      = bus.halt;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int len;
    int dv;
    int hold;
    logic halt;
    int steps;
    int busy;
    int gap;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  int exp2[5];

  int cyc, n_steps, n_busy, n_clkhi, first_step, last_step, first_busy, last_busy;
  int gap_bad, clk_bad, want_gap, exp_ticks;
  logic prev_clk = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic clear();
    cyc = 0; n_steps = 0; n_busy = 0; n_clkhi = 0;
    first_step = -1; last_step = -1; first_busy = -1; last_busy = -1;
    gap_bad = 0; clk_bad = 0;
  endtask

  task automatic tick();
    logic rise;
    @(negedge clk);
    cyc++;
    rise = (bus.step_clk === 1'b1) && !prev_clk;
    if (rise != (bus.step_en === 1'b1)) clk_bad++;
    if (bus.step_en === 1'b1) begin
      n_steps++;
      if (first_step < 0) first_step = cyc;
      if (last_step >= 0 && want_gap != 0 && (cyc - last_step) != want_gap) gap_bad++;
      last_step = cyc;
    end
    if (bus.busy === 1'b1) begin
      n_busy++;
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (bus.step_clk === 1'b1) n_clkhi++;
    prev_clk = (bus.step_clk === 1'b1);
  endtask

  task automatic window(input int n);
    repeat (n) tick();
  endtask

  // Clean press; settings are scrambled once the press has been accepted.
  task automatic press(input int hold, input int lo, input logic [1:0] m, input int len, input int dv);
    bus.mode = m;
    bus.burst_len = 8'(len);
    bus.div = 16'(dv);
    bus.button = 1'b1;
    repeat (hold) tick();
    bus.button = 1'b0;
    for (int i = 0; i < lo; i++) begin
      tick();
      if (i == 2) begin
        bus.mode = ~m;
        bus.burst_len = (len == 0) ? 8'd7 : 8'd0;
        bus.div = 16'hFFFF;
      end
    end
  endtask

  initial begin
    vecs[0] = '{2'b00, 0, 0,  8, 1'b0, 1, 0,  0};
    vecs[1] = '{2'b01, 3, 4,  8, 1'b0, 3, 11, 5};
    vecs[2] = '{2'b01, 0, 4,  8, 1'b0, 0, 0,  0};
    vecs[3] = '{2'b11, 3, 4,  8, 1'b0, 0, 0,  0};
    vecs[4] = '{2'b01, 1, 9,  8, 1'b0, 1, 1,  0};
    vecs[5] = '{2'b01, 2, 0,  8, 1'b0, 2, 5,  4};
    vecs[6] = '{2'b01, 2, 2,  8, 1'b0, 2, 5,  4};
    vecs[7] = '{2'b01, 3, 5,  8, 1'b0, 3, 13, 6};
    vecs[8] = '{2'b01, 2, 4,  8, 1'b1, 0, 0,  0};
    vecs[9] = '{2'b00, 0, 0, 30, 1'b0, 1, 0,  0};
    exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 0; exp2[4] = 1;

    bus.button = 1'b0; bus.mode = 2'b00; bus.burst_len = '0; bus.div = '0; bus.halt = 1'b0;
    want_gap = 0; exp_ticks = 0;
    clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_step_en", bus.step_en, 0);
    check("rst_step_clk", bus.step_clk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ticks", bus.ticks, 0);
    reset = 1'b0;
    window(3);
    check("post_rst_ticks", bus.ticks, 0);
    check("post_rst_ticks2", bus2.ticks, 0);
    check("post_rst_steps", n_steps, 0);

    // Bouncing press: 3 high, 1 low, 6 high
    clear();
    bus.button = 1'b1; repeat (3) tick();
    bus.button = 1'b0; tick();
    bus.button = 1'b1; repeat (6) tick();
    bus.button = 1'b0; repeat (8) tick();
    window(30);
    exp_ticks = 1;
    check("bounce_steps", n_steps, 1);
    check("bounce_first", first_step, 11);
    check("bounce_clkhi", n_clkhi, 2);
    check("bounce_clk_align", clk_bad, 0);
    check("bounce_ticks", bus.ticks, exp_ticks);

    for (int i = 0; i < NV; i++) begin
      clear();
      want_gap = vecs[i].gap;
      bus.halt = vecs[i].halt;
      press(vecs[i].hold, 8, vecs[i].mode, vecs[i].len, vecs[i].dv);
      window(40);
      bus.halt = 1'b0;
      exp_ticks = (exp_ticks + vecs[i].steps) % 256;
      check($sformatf("v%0d_steps", i), n_steps, vecs[i].steps);
      check($sformatf("v%0d_busy", i), n_busy, vecs[i].busy);
      check($sformatf("v%0d_gap", i), gap_bad, 0);
      check($sformatf("v%0d_clk_align", i), clk_bad, 0);
      check($sformatf("v%0d_clkhi", i), n_clkhi, 2 * vecs[i].steps);
      check($sformatf("v%0d_ticks", i), bus.ticks, exp_ticks);
      if (vecs[i].steps > 0) check($sformatf("v%0d_first", i), first_step, 7);
      if (vecs[i].busy > 0) begin
        check($sformatf("v%0d_busy_start", i), first_busy, first_step);
        check($sformatf("v%0d_busy_end", i), last_busy, last_step);
      end
    end

    // Free-run, div=0 -> period 4; second press stops it
    clear();
    want_gap = 4;
    press(8, 8, 2'b10, 0, 0);
    window(30);
    check("frun_steps", n_steps, 10);
    check("frun_gap", gap_bad, 0);
    check("frun_first", first_step, 7);
    check("frun_busy", n_busy, 40);
    clear();
    press(8, 8, 2'b00, 0, 0);
    check("frun_stop_steps", n_steps, 2);
    check("frun_stop_busy_end", last_busy, 6);
    clear();
    window(30);
    check("frun_after_steps", n_steps, 0);
    check("frun_after_busy", n_busy, 0);
    exp_ticks = (exp_ticks + 12) % 256;
    check("frun_ticks", bus.ticks, exp_ticks);

    // Halt during the 2nd pulse of a long burst
    clear();
    want_gap = 5;
    press(8, 4, 2'b01, 10, 4);
    bus.halt = 1'b1;
    tick();
    check("haltA_pulse_completes", bus.step_clk, 1);
    check("haltA_busy_low", bus.busy, 0);
    window(20);
    bus.halt = 1'b0;
    window(10);
    exp_ticks = (exp_ticks + 2) % 256;
    check("haltA_steps", n_steps, 2);
    check("haltA_clkhi", n_clkhi, 4);
    check("haltA_busy", n_busy, 6);
    check("haltA_ticks", bus.ticks, exp_ticks);

    // Halt in the same cycle the period expires
    clear();
    press(8, 8, 2'b01, 10, 4);
    bus.halt = 1'b1;
    window(20);
    bus.halt = 1'b0;
    exp_ticks = (exp_ticks + 2) % 256;
    check("haltB_steps", n_steps, 2);
    check("haltB_busy", n_busy, 10);
    check("haltB_ticks", bus.ticks, exp_ticks);

    // Reset while step_clk is high mid-burst
    clear();
    want_gap = 0;
    press(8, 4, 2'b01, 3, 4);
    check("rstmid_pre_clk", bus.step_clk, 1);
    reset = 1'b1;
    #1;
    check("rstmid_step_clk", bus.step_clk, 0);
    check("rstmid_step_en", bus.step_en, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_ticks", bus.ticks, 0);
    check("rstmid_ticks2", bus2.ticks, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ticks = 0;
    clear();
    window(40);
    check("rstmid_after_steps", n_steps, 0);
    check("rstmid_after_busy", n_busy, 0);
    check("rstmid_after_clkhi", n_clkhi, 0);

    // Tick wrap on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      clear();
      press(8, 8, 2'b00, 0, 0);
      window(4);
      check($sformatf("wrap%0d_ticks2", k), bus2.ticks, exp2[k]);
      check($sformatf("wrap%0d_ticks", k), bus.ticks, k + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_clock_ctrl.md
STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000: consecutive stable cycles needed to accept a button press or release.
REQ-002 Parameter PULSE_CYCLES, default 1: number of clk cycles step_clk stays high per step.
REQ-003 Parameter BURST_W, default 8: width of burst_len.
REQ-004 Parameter DIV_W, default 16: width of div.
REQ-005 Parameter TICK_W, default 8: width of ticks.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 button  input  1  raw, asynchronous, bouncing push-button.
REQ-009 mode  input  2  00 single-step, 01 burst, 10 free-run, 11 disabled.
REQ-010 burst_len  input  BURST_W  steps per press in burst mode.
REQ-011 div  input  DIV_W  step period control for burst and free-run.
REQ-012 halt  input  1  synchronous stop request, e.g. from CPU halt.
REQ-013 step_en  output  1  one-clk-cycle strobe per step, for clock-enable use.
REQ-014 step_clk  output  1  registered step clock, high PULSE_CYCLES cycles per step.
REQ-015 busy  output  1  high while a burst or free-run is in progress.
REQ-016 ticks  output  TICK_W  count of steps issued.

Function
REQ-017 button SHALL pass through a 2-flop synchroniser before any other use.
REQ-018 A press SHALL be accepted after the synchronised button is high for DEBOUNCE_CYCLES consecutive cycles; any low cycle restarts the count.
REQ-019 After a press is accepted, no further press SHALL be accepted until the button has been low for DEBOUNCE_CYCLES consecutive cycles.
REQ-020 mode, burst_len and div SHALL be sampled only in the cycle a press is accepted; changes while busy SHALL be ignored.
REQ-021 FSM states: IDLE, RUN.
REQ-022 IDLE, press accepted, mode 00: one step_en in the cycle after acceptance; remain IDLE.
REQ-023 IDLE, press accepted, mode 01, burst_len > 0: go to RUN; issue burst_len steps; then return to IDLE.
REQ-024 IDLE, press accepted, mode 01, burst_len = 0: no step; remain IDLE.
REQ-025 IDLE, press accepted, mode 10: go to RUN; issue steps indefinitely; next accepted press returns to IDLE, with no further step.
REQ-026 Mode 11: presses are accepted (debounce state advances) but produce no step.
REQ-027 In RUN the first step SHALL occur the cycle after acceptance; the step period SHALL be max(div+1, 2*PULSE_CYCLES) cycles.
REQ-028 step_clk SHALL rise in the same cycle as step_en and stay high exactly PULSE_CYCLES cycles.
REQ-029 busy SHALL be high exactly while in RUN.
REQ-030 halt high in RUN: no further step_en from that cycle on; a step_clk pulse already in progress completes; return to IDLE.
REQ-031 halt high in IDLE: accepted presses produce no step.
REQ-032 ticks SHALL increment by 1 on each step_en and wrap from 2^TICK_W-1 to 0.
REQ-033 A halt and a period expiry in the same cycle: halt wins; no step.

Reset
REQ-034 On reset: FSM=IDLE, step_en=0, step_clk=0, busy=0, ticks=0, counters=0, synchroniser=0, release-armed (next stable-high run is accepted).
REQ-035 Reset mid-burst or mid-pulse SHALL drop all outputs to 0 immediately; no step is issued after reset deasserts until a new press is accepted.

Structure
REQ-036 Mode encodings and FSM state encodings SHALL live in the shared package, e.g. step_pkg.
REQ-037 The synchroniser and debouncer SHALL be one sub-module, btn_debounce (outputs a one-cycle press_acc pulse), with DEBOUNCE_CYCLES passed down.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2 unless stated)
REQ-038 Button high 3 cycles, low 1 cycle, high 6 cycles, mode 00 -> exactly one step_en; ticks 0->1; step_clk high 2 cycles.
REQ-039 Mode 01, burst_len=3, div=4, one clean press -> step_en at t, t+5 and t+10; busy high t..t+10 only; ticks=3.
REQ-040 Mode 10, div=0 -> period 4 (2*PULSE_CYCLES); second press stops it; busy falls; no step after stop.
REQ-041 Mode 01, burst_len=10, halt asserted after the 2nd step -> no 3rd step_en, busy low, ticks=2.
REQ-042 TICK_W=2, five single steps -> ticks sequence 1,2,3,0,1.
REQ-043 Reset asserted while step_clk is high in a burst -> step_clk, busy and ticks 0 that same cycle; no steps after release without a new press.
